enc_event_fifo: RTL and testbench
=================================

// Module: enc_event_fifo
// PURPOSE
//  Downstream consumer of the 8x3 encoder's code (x2..x0) and valid (v) outputs.
//  Registers each new encoded event, meaning a rising v or a changed code while v=1,
//  into a small FIFO. Presents the events to the next stage over a valid/ready handshake.
//  Flags and counts events lost to a full FIFO.
// PARAMETERS
//  CODE_W   3    width of encoded code (log2 of encoder inputs)
//  DEPTH    8    FIFO entries; power of two, >=2
//  CNT_W    8    width of saturating drop counter
// PORTS
//  clk        in   1              single clock, rising edge
//  rst        in   1              reset, asynchronous, active-high
//  en         in   1              capture enable; 0 = ignore encoder, FIFO still drains
//  code_in    in   CODE_W         encoder code {x2,x1,x0}
//  code_v     in   1              encoder valid v
//  out_code   out  CODE_W         head-of-FIFO code
//  out_valid  out  1              head entry valid
//  out_ready  in   1              consumer accepts head when out_valid=1
//  count      out  log2(DEPTH)+1  current occupancy, 0..DEPTH
//  full       out  1              count==DEPTH
//  empty      out  1              count==0
//  overflow   out  1              sticky: an event was dropped
//  drop_cnt   out  CNT_W          dropped-event count, saturates at all-ones
//  clr_ovf    in   1              synchronous clear of overflow and drop_cnt
// BEHAVIOUR
//  Reset (async, rst=1): pointers 0, count=0, empty=1, full=0, out_valid=0,
//   out_code=0, overflow=0, drop_cnt=0, prev_v=0, prev_code=0. Holds while rst=1.
//  Event detect, sampled each clk:
//   evt = en & code_v & (~prev_v | code_in!=prev_code).
//   prev_v/prev_code update every cycle from code_v/code_in, regardless of en.
//   A held code therefore yields exactly one event.
//  Push: evt & (~full | pop). Pop: out_valid & out_ready.
//  Latency: event sampled at edge N appears on out_code/out_valid after edge N+1.
//   There is no empty bypass.
//  count next = count + push - pop. Pointers wrap modulo DEPTH.
//  Simultaneous push+pop when full: both occur, count stays DEPTH, no drop.
//  Simultaneous push+pop when empty: the push is stored and the pop cannot occur
//   (out_valid=0), so count becomes 1.
//  Drop: evt & full & ~pop. Sets overflow=1 and increments drop_cnt (saturating).
//  clr_ovf: clears overflow and drop_cnt next edge. A drop in the same cycle wins:
//   overflow=1, drop_cnt=1.
//  out_valid=~empty. out_code=mem[rd_ptr]. Both are stable while out_valid & ~out_ready.
//  en=0: no pushes; pops continue.
//  Reset mid-operation discards all contents immediately, without waiting for a clock.
// STRUCTURE
//  Package enc_pkg: CODE_W, DEPTH default, CNT_W, function clog2.
//  Sub-module enc_evt_detect: prev_v/prev_code registers plus the evt equation.
//  FIFO storage, pointers and counters stay in this module.
// TESTING
//  1 Reset: rst=1 mid-run with count=3 -> count=0, empty=1, out_valid=0 with no clk edge.
//  2 Sweep: drive code 0..7, each held 3 cycles with v=1, out_ready=1
//     -> exactly 8 outputs 0,1,...,7, each arriving 1 cycle after its input.
//  3 Dedup: code 5 held 10 cycles, v=1 -> one event.
//     Then v 1->0->1 with code 5 -> second event 5.
//  4 Overflow: out_ready=0, 10 distinct events -> full=1, count=8, overflow=1, drop_cnt=2.
//     FIFO holds the first 8 in order.
//  5 Full push+pop: full, out_ready=1, new event -> count stays 8, drop_cnt unchanged.
//     Then clr_ovf=1 -> overflow=0, drop_cnt=0.
//  6 Enable: en=0 with changing codes -> no pushes, existing entries drain.
//     en=1 with code held -> event captured only on the next change or v rise.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared widths and helpers for the encoder event FIFO slice.
package enc_pkg;

    localparam int CODE_W    = 3;
    localparam int DEPTH_DEF = 8;
    localparam int CNT_W     = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/enc_event_fifo_if.sv
// Head-of-FIFO valid/ready handshake between the event FIFO and its consumer.
interface enc_event_fifo_if #(parameter int W = enc_pkg::CODE_W);

    logic [W-1:0] out_code;
    logic         out_valid;
    logic         out_ready;

    modport master (output out_code, output out_valid, input out_ready);
    modport slave  (input out_code, input out_valid, output out_ready);

endinterface

// File: rtl/enc_evt_detect.sv
// Turns the encoder's code/valid stream into one-cycle registered event pulses.
module enc_evt_detect
    import enc_pkg::*;
#(
    parameter int W = CODE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [W-1:0] i_code,
    input  logic         i_v,
    output logic         o_evt,
    output logic [W-1:0] o_code
);

    logic         r_prev_v;
    logic [W-1:0] r_prev_code;
    logic         r_evt;
    logic [W-1:0] r_code;
    logic         w_evt;

    // History tracks the encoder even while capture is disabled, so a held code never re-fires.
    assign w_evt = i_en & i_v & (~r_prev_v | (i_code != r_prev_code));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_v    <= 1'b0;
            r_prev_code <= '0;
            r_evt       <= 1'b0;
            r_code      <= '0;
        end else begin
            r_prev_v    <= i_v;
            r_prev_code <= i_code;
            r_evt       <= w_evt;
            r_code      <= i_code;
        end
    end

    assign o_evt  = r_evt;
    assign o_code = r_code;

endmodule

// File: rtl/enc_event_fifo.sv
// Event FIFO behind the 8x3 encoder: stores detected code events, drains over valid/ready, counts drops.
module enc_event_fifo
    import enc_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [CODE_W-1:0]         code_in,
    input  logic                      code_v,
    enc_event_fifo_if.master          ob,
    output logic [clog2(DEPTH):0]     count,
    output logic                      full,
    output logic                      empty,
    output logic                      overflow,
    output logic [CNT_W-1:0]          drop_cnt,
    input  logic                      clr_ovf
);

    localparam int AW = clog2(DEPTH);

    logic [CODE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr;
    logic [AW-1:0]     r_rd;
    logic [AW:0]       r_count;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_drop;

    logic              w_evt;
    logic [CODE_W-1:0] w_evt_code;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;

    enc_evt_detect #(.W(CODE_W)) u_detect (
        .clk    (clk),
        .rst    (rst),
        .i_en   (en),
        .i_code (code_in),
        .i_v    (code_v),
        .o_evt  (w_evt),
        .o_code (w_evt_code)
    );

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = ~w_empty & ob.out_ready;
    // A pop frees the head slot in the same edge, so a full FIFO can still accept.
    assign w_push  = w_evt & (~w_full | w_pop);
    assign w_drop  = w_evt & w_full & ~w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= w_evt_code;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A drop in the same cycle as a clear restarts the tally at one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (clr_ovf)
                r_drop <= CNT_W'(1);
            else if (r_drop != '1)
                r_drop <= r_drop + CNT_W'(1);
        end else if (clr_ovf) begin
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end
    end

    assign ob.out_valid = ~w_empty;
    assign ob.out_code  = r_mem[r_rd];
    assign count        = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign overflow     = r_ovf;
    assign drop_cnt     = r_drop;

endmodule

// File: tb/tb_enc_event_fifo.sv
// Bench for enc_event_fifo: vector table plus scoreboarded multi-cycle sequences.
module tb_enc_event_fifo;
    import enc_pkg::*;

    localparam int D  = 8;
    localparam int CW = clog2(D) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              code_v;
    logic              clr_ovf;
    logic [CODE_W-1:0] code_in;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic [CNT_W-1:0]  drop_cnt;

    enc_event_fifo_if ob();

    enc_event_fifo #(.DEPTH(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .code_in  (code_in),
        .code_v   (code_v),
        .ob       (ob),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;
    int nHs        = 0;
    int hs0;
    int lastPop    = -1;

    logic [CODE_W-1:0] sbq [$];
    logic              mPrevV;
    logic [CODE_W-1:0] mPrevCode;
    logic              mPend;
    logic [CODE_W-1:0] mPendCode;
    logic              mOvf;
    int                mDrop;

    typedef struct {
        logic              e;
        logic              v;
        logic [CODE_W-1:0] c;
        logic              r;
        int                expCount;
        logic              expValid;
        logic [CODE_W-1:0] expCode;
    } vec_t;

    vec_t tbl [12];

    task automatic checkOutput(input string name, input int act, input int exp);
        checkCount++;
        if (act == exp) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic applyStimulus(input logic e, input logic v, input logic [CODE_W-1:0] c,
                                 input logic r, input logic cl);
        en           = e;
        code_v       = v;
        code_in      = c;
        ob.out_ready = r;
        clr_ovf      = cl;
    endtask

    task automatic modelReset();
        sbq.delete();
        mPrevV    = 1'b0;
        mPrevCode = '0;
        mPend     = 1'b0;
        mPendCode = '0;
        mOvf      = 1'b0;
        mDrop     = 0;
    endtask

    // One clock: predict from the model, advance, then compare DUT against the model.
    task automatic stepClock();
        logic              hs;
        logic [CODE_W-1:0] hc;
        logic              mPop, mPush, mDropNow, evtNow;
        logic [CODE_W-1:0] exp;
        hs       = ob.out_valid & ob.out_ready;
        hc       = ob.out_code;
        mPop     = (sbq.size() != 0) && ob.out_ready;
        mPush    = mPend && ((sbq.size() < D) || mPop);
        mDropNow = mPend && (sbq.size() == D) && !mPop;
        evtNow   = en & code_v & (!mPrevV | (code_in != mPrevCode));
        @(posedge clk);
        #1;
        checkOutput("handshake", int'(hs), int'(mPop));
        if (hs) nHs++;
        if (mPop) begin
            exp = sbq.pop_front();
            if (hs) begin
                checkOutput("pop code", int'(hc), int'(exp));
                lastPop = int'(hc);
            end
        end
        if (mPush) sbq.push_back(mPendCode);
        if (mDropNow) begin
            mOvf  = 1'b1;
            mDrop = clr_ovf ? 1 : ((mDrop == 255) ? 255 : mDrop + 1);
        end else if (clr_ovf) begin
            mOvf  = 1'b0;
            mDrop = 0;
        end
        mPend     = evtNow;
        mPendCode = code_in;
        mPrevV    = code_v;
        mPrevCode = code_in;
        checkOutput("count", int'(count), sbq.size());
        checkOutput("out_valid", int'(ob.out_valid), int'(sbq.size() != 0));
        checkOutput("full", int'(full), int'(sbq.size() == D));
        checkOutput("empty", int'(empty), int'(sbq.size() == 0));
        checkOutput("overflow", int'(overflow), int'(mOvf));
        checkOutput("drop_cnt", int'(drop_cnt), mDrop);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 3'd5, 1'b1, 0, 1'b0, 3'd0};
        tbl[1]  = '{1'b1, 1'b1, 3'd5, 1'b1, 1, 1'b1, 3'd5};
        tbl[2]  = '{1'b1, 1'b1, 3'd5, 1'b1, 0, 1'b0, 3'd0};
        tbl[3]  = '{1'b1, 1'b0, 3'd5, 1'b1, 0, 1'b0, 3'd0};
        tbl[4]  = '{1'b1, 1'b1, 3'd5, 1'b1, 0, 1'b0, 3'd0};
        tbl[5]  = '{1'b1, 1'b1, 3'd5, 1'b1, 1, 1'b1, 3'd5};
        tbl[6]  = '{1'b1, 1'b1, 3'd6, 1'b1, 0, 1'b0, 3'd0};
        tbl[7]  = '{1'b1, 1'b1, 3'd6, 1'b1, 1, 1'b1, 3'd6};
        tbl[8]  = '{1'b0, 1'b1, 3'd2, 1'b1, 0, 1'b0, 3'd0};
        tbl[9]  = '{1'b1, 1'b1, 3'd2, 1'b1, 0, 1'b0, 3'd0};
        tbl[10] = '{1'b1, 1'b1, 3'd3, 1'b1, 0, 1'b0, 3'd0};
        tbl[11] = '{1'b1, 1'b1, 3'd3, 1'b1, 1, 1'b1, 3'd3};

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        modelReset();
        #3;
        checkOutput("reset count", int'(count), 0);
        checkOutput("reset empty", int'(empty), 1);
        checkOutput("reset full", int'(full), 0);
        checkOutput("reset out_valid", int'(ob.out_valid), 0);
        checkOutput("reset out_code", int'(ob.out_code), 0);
        checkOutput("reset overflow", int'(overflow), 0);
        checkOutput("reset drop_cnt", int'(drop_cnt), 0);
        #9 rst = 1'b0;
        @(posedge clk);
        #1;

        // Table: dedup, re-rise, enable gating and one-cycle latency
        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i].e, tbl[i].v, tbl[i].c, tbl[i].r, 1'b0);
            stepClock();
            checkOutput($sformatf("vec%0d count", i), int'(count), tbl[i].expCount);
            checkOutput($sformatf("vec%0d valid", i), int'(ob.out_valid), int'(tbl[i].expValid));
            if (tbl[i].expValid)
                checkOutput($sformatf("vec%0d code", i), int'(ob.out_code), int'(tbl[i].expCode));
        end

        // Asynchronous reset with three entries held
        applyStimulus(1'b1, 1'b1, 3'd1, 1'b0, 1'b0); stepClock();
        applyStimulus(1'b1, 1'b1, 3'd2, 1'b0, 1'b0); stepClock();
        stepClock();
        checkOutput("pre-reset count", int'(count), 3);
        #2 rst = 1'b1;
        #1;
        checkOutput("async reset count", int'(count), 0);
        checkOutput("async reset empty", int'(empty), 1);
        checkOutput("async reset out_valid", int'(ob.out_valid), 0);
        modelReset();
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
            stepClock();
        end

        // Sweep 0..7, each held three cycles
        hs0 = nHs;
        for (int c = 0; c < 8; c++) begin
            for (int h = 0; h < 3; h++) begin
                applyStimulus(1'b1, 1'b1, 3'(c), 1'b1, 1'b0);
                stepClock();
                if (h == 0) checkOutput("sweep not early", int'(ob.out_valid), 0);
                if (h == 1) begin
                    checkOutput("sweep valid", int'(ob.out_valid), 1);
                    checkOutput("sweep code", int'(ob.out_code), c);
                end
            end
        end
        stepClock();
        stepClock();
        checkOutput("sweep outputs", nHs - hs0, 8);

        // Held code yields one event, re-rise yields another
        hs0 = nHs;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 3'd5, 1'b1, 1'b0);
            stepClock();
        end
        checkOutput("dedup events", nHs - hs0, 1);
        applyStimulus(1'b1, 1'b0, 3'd5, 1'b1, 1'b0); stepClock();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 3'd5, 1'b1, 1'b0);
            stepClock();
        end
        checkOutput("re-rise events", nHs - hs0, 2);
        checkOutput("re-rise code", lastPop, 5);

        // Overflow: ten distinct events with the consumer stalled
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 3'((i + 6) % 8), 1'b0, 1'b0);
            stepClock();
        end
        stepClock();
        checkOutput("ovf full", int'(full), 1);
        checkOutput("ovf count", int'(count), 8);
        checkOutput("ovf flag", int'(overflow), 1);
        checkOutput("ovf drop_cnt", int'(drop_cnt), 2);
        checkOutput("ovf head", int'(ob.out_code), 6);

        // Push and pop together while full
        applyStimulus(1'b1, 1'b1, 3'd0, 1'b0, 1'b0); stepClock();
        applyStimulus(1'b1, 1'b1, 3'd0, 1'b1, 1'b0); stepClock();
        checkOutput("full push+pop count", int'(count), 8);
        checkOutput("full push+pop drop_cnt", int'(drop_cnt), 2);
        applyStimulus(1'b1, 1'b1, 3'd0, 1'b0, 1'b1); stepClock();
        checkOutput("clr overflow", int'(overflow), 0);
        checkOutput("clr drop_cnt", int'(drop_cnt), 0);
        applyStimulus(1'b1, 1'b1, 3'd1, 1'b0, 1'b0); stepClock();
        applyStimulus(1'b1, 1'b1, 3'd1, 1'b0, 1'b1); stepClock();
        checkOutput("clr+drop overflow", int'(overflow), 1);
        checkOutput("clr+drop drop_cnt", int'(drop_cnt), 1);

        // Enable low: codes change but only draining happens
        hs0 = nHs;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 3'(i), 1'b1, 1'b0);
            stepClock();
        end
        checkOutput("en0 drained", nHs - hs0, 8);
        checkOutput("en0 count", int'(count), 0);
        hs0 = nHs;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
            stepClock();
        end
        checkOutput("en1 held no event", nHs - hs0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 3'd4, 1'b1, 1'b0);
            stepClock();
        end
        checkOutput("en1 change event", nHs - hs0, 1);
        checkOutput("en1 change code", lastPop, 4);
        checkOutput("end empty", int'(empty), 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
